// File: rtl/light_package.sv
// Light colour encoding shared with the traffic light controller.
// Sensor conditioning compares feedback against these values.
package light_package;

  typedef enum logic [1:0] {
    red    = 2'd0,
    yellow = 2'd1,
    green  = 2'd2
  } colors;

endpackage

// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared constants and lane indices for the sensor conditioner.
// Lane values double as bit positions in lane_fault.
package traffic_sensor_conditioner_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 3;
  localparam int unsigned DEF_STUCK_CYCLES    = 256;
  localparam int unsigned N_LANES             = 5;

  typedef enum logic [2:0] {
    L_E_LEFT = 3'd4,
    L_E_STR  = 3'd3,
    L_W_LEFT = 3'd2,
    L_W_STR  = 3'd1,
    L_NS     = 3'd0
  } lane_e;

endpackage

// File: rtl/traffic_sensor_conditioner_lane.sv
// One detector lane: sync, debounce, request latch,
// stuck-on watchdog and the registered demand output.
module sensor_lane
  import light_package::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned STUCK_CYCLES    = 256
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  raw,
  input  colors light,
  output logic  sensor,
  output logic  fault
);

  localparam logic [3:0]  DEB = 4'(DEBOUNCE_CYCLES);
  localparam logic [15:0] STK = 16'(STUCK_CYCLES);

  logic        s1_q, s2_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        stable_q, stable_d;
  logic        req_q, req_d;
  logic [15:0] stuck_q, stuck_d;
  logic        fault_q, fault_d;
  logic        sensor_q, sensor_d;
  logic        rise;

  // Next-state for debounce, latch, watchdog and output.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (s2_q != stable_q) begin
      if (cnt_q + 4'd1 == DEB) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    rise  = stable_d & ~stable_q;
    req_d = req_q;
    if (rise) begin
      req_d = 1'b1;
    end else if (light == green && !stable_q) begin
      req_d = 1'b0;
    end
    stuck_d = stuck_q;
    if (!stable_q) begin
      stuck_d = '0;
    end else if (stuck_q != 16'hFFFF) begin
      stuck_d = stuck_q + 16'd1;
    end
    fault_d  = fault_q | (stuck_d == STK);
    sensor_d = stable_q | req_q | fault_q;
  end

  // All lane state, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      req_q    <= 1'b0;
      stuck_q  <= '0;
      fault_q  <= 1'b0;
      sensor_q <= 1'b0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      req_q    <= req_d;
      stuck_q  <= stuck_d;
      fault_q  <= fault_d;
      sensor_q <= sensor_d;
    end
  end

  assign sensor = sensor_q;
  assign fault  = fault_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions five raw loop detectors into controller demands.
// Each lane is an independent sensor_lane instance.
module traffic_sensor_conditioner
  import light_package::*;
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_e_left,
  input  logic       raw_e_str,
  input  logic       raw_w_left,
  input  logic       raw_w_str,
  input  logic       raw_ns,
  input  colors      e_left_light,
  input  colors      e_str_light,
  input  colors      w_left_light,
  input  colors      w_str_light,
  input  colors      ns_light,
  output logic       e_left_sensor,
  output logic       e_str_sensor,
  output logic       w_left_sensor,
  output logic       w_str_sensor,
  output logic       ns_sensor,
  output logic [4:0] lane_fault
);

  logic [N_LANES-1:0] raw_v;
  logic [N_LANES-1:0] sens_v;
  colors              light_v [N_LANES];

  assign raw_v[L_E_LEFT] = raw_e_left;
  assign raw_v[L_E_STR]  = raw_e_str;
  assign raw_v[L_W_LEFT] = raw_w_left;
  assign raw_v[L_W_STR]  = raw_w_str;
  assign raw_v[L_NS]     = raw_ns;

  assign light_v[L_E_LEFT] = e_left_light;
  assign light_v[L_E_STR]  = e_str_light;
  assign light_v[L_W_LEFT] = w_left_light;
  assign light_v[L_W_STR]  = w_str_light;
  assign light_v[L_NS]     = ns_light;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    sensor_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_v[i]),
      .light (light_v[i]),
      .sensor(sens_v[i]),
      .fault (lane_fault[i])
    );
  end

  assign e_left_sensor = sens_v[L_E_LEFT];
  assign e_str_sensor  = sens_v[L_E_STR];
  assign w_left_sensor = sens_v[L_W_LEFT];
  assign w_str_sensor  = sens_v[L_W_STR];
  assign ns_sensor     = sens_v[L_NS];

endmodule
